// File: rtl/enum_alu_pkg.sv
// Shared opcode constants, FSM state type and opcode helper for the shared-ALU arbiter.
// The MULX state exists only when ENUM_ALU_ARB_MUL_PIPE_EN is defined.
package enum_alu_pkg;

  localparam logic [7:0] OP_INC = 8'd17;
  localparam logic [7:0] OP_ADD = 8'd18;
  localparam logic [7:0] OP_SUB = 8'd19;

`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_MULX = 2'd2,
    ST_DONE = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;
`endif

  // Every opcode outside the three named ones selects the multiply.
  function automatic logic is_mul(input logic [7:0] op);
    return !((op == OP_INC) || (op == OP_ADD) || (op == OP_SUB));
  endfunction

endpackage

// File: rtl/enum_alu.sv
// Purely combinational opcode-selected ALU: INC, ADD, SUB, truncated MUL, all modulo 2^WIDTH.
module enum_alu
  import enum_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [7:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  logic [2*WIDTH-1:0] prod;

  assign prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  always_comb begin
    y = prod[WIDTH-1:0];
    case (op)
      OP_INC:  y = a + WIDTH'(1);
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      default: y = prod[WIDTH-1:0];
    endcase
  end

endmodule

// File: rtl/enum_alu_arbiter.sv
// Round-robin arbiter sequencing two requesters through one shared ALU, one operation at a time.
// Optional ENUM_ALU_ARB_MUL_PIPE_EN adds a MULX stage that registers the multiply separately.
//
// state | meaning
// IDLE  | grant a valid requester, capture its op/operands
// EXEC  | compute result (or stage MUL operands when pipelined)
// MULX  | register pipelined product (macro builds only)
// DONE  | hold response until RESP_READY, then advance PTR
module enum_alu_arbiter
  import enum_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ0_VALID,
  output logic             REQ0_READY,
  input  logic [7:0]       REQ0_OP,
  input  logic [WIDTH-1:0] REQ0_A,
  input  logic [WIDTH-1:0] REQ0_B,
  input  logic             REQ1_VALID,
  output logic             REQ1_READY,
  input  logic [7:0]       REQ1_OP,
  input  logic [WIDTH-1:0] REQ1_A,
  input  logic [WIDTH-1:0] REQ1_B,
  output logic             RESP_VALID,
  input  logic             RESP_READY,
  output logic [WIDTH-1:0] RESP_DATA,
  output logic             RESP_ID
);

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             id_q, id_d;
  logic             resp_id_q, resp_id_d;
  logic [7:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] resp_data_q, resp_data_d;
  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  logic             grant_valid, grant_id, accept;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
  logic [WIDTH-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
`endif

  // Grant: sole valid requester wins; on contention PTR decides.
  always_comb begin
    grant_valid = REQ0_VALID || REQ1_VALID;
    grant_id    = 1'b0;
    if (REQ0_VALID && REQ1_VALID) grant_id = ptr_q;
    else if (REQ1_VALID)          grant_id = 1'b1;
  end

  assign accept     = !RST && (state_q == ST_IDLE) && grant_valid;
  assign REQ0_READY = accept && !grant_id;
  assign REQ1_READY = accept && grant_id;
  assign RESP_VALID = (state_q == ST_DONE);
  assign RESP_DATA  = resp_data_q;
  assign RESP_ID    = resp_id_q;

  always_comb begin
    alu_a = a_q;
    alu_b = b_q;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
    if (state_q == ST_MULX) begin
      alu_a = mul_a_q;
      alu_b = mul_b_q;
    end
`endif
  end

  enum_alu #(.WIDTH(WIDTH)) u_alu (
    .op (op_q),
    .a  (alu_a),
    .b  (alu_b),
    .y  (alu_y)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          id_d    = grant_id;
          op_d    = grant_id ? REQ1_OP : REQ0_OP;
          a_d     = grant_id ? REQ1_A  : REQ0_A;
          b_d     = grant_id ? REQ1_B  : REQ0_B;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        resp_id_d = id_q;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
        if (is_mul(op_q)) begin
          mul_a_d = a_q;
          mul_b_d = b_q;
          state_d = ST_MULX;
        end else begin
          resp_data_d = alu_y;
          state_d     = ST_DONE;
        end
`else
        resp_data_d = alu_y;
        state_d     = ST_DONE;
`endif
      end
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
      ST_MULX: begin
        resp_data_d = alu_y;
        state_d     = ST_DONE;
      end
`endif
      ST_DONE: begin
        if (RESP_READY) begin
          ptr_d   = ~resp_id_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      op_q        <= 8'd0;
      a_q         <= '0;
      b_q         <= '0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
      mul_a_q     <= '0;
      mul_b_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_enum_alu_arbiter.sv
// Directed bench for enum_alu_arbiter: a cycle-level expectation model checked every cycle
// plus literal checks of captured responses and latency.
module tb_enum_alu_arbiter;

`ifdef ENUM_ALU_ARB_MUL_PIPE_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = 2;
`endif

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       v0 = 1'b0, v1 = 1'b0, resp_ready = 1'b1;
  logic [7:0] op0 = 8'd0, a0 = 8'd0, b0 = 8'd0;
  logic [7:0] op1 = 8'd0, a1 = 8'd0, b1 = 8'd0;
  logic       r0, r1, rv, rid;
  logic [7:0] rdata;

  always #5 CLK = ~CLK;

  enum_alu_arbiter #(.WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .REQ0_VALID (v0),
    .REQ0_READY (r0),
    .REQ0_OP    (op0),
    .REQ0_A     (a0),
    .REQ0_B     (b0),
    .REQ1_VALID (v1),
    .REQ1_READY (r1),
    .REQ1_OP    (op1),
    .REQ1_A     (a1),
    .REQ1_B     (b1),
    .RESP_VALID (rv),
    .RESP_READY (resp_ready),
    .RESP_DATA  (rdata),
    .RESP_ID    (rid)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {int id; int data;} resp_t;
  resp_t act[$];
  int acc0 = 0, acc1 = 0, acc_cyc = 0, last_lat = -1;
  logic prev_rv = 1'b0;

  // Expectation model: "one job in flight, visible after a fixed latency".
  logic m_init = 1'b0, m_busy = 1'b0, m_ptr = 1'b0, m_id = 1'b0;
  int   m_due = 0, m_data = 0;

  task automatic chk(input bit ok, input string name, input int got, input int exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int model_result(input int op, input int a, input int b);
    case (op)
      17:      return (a + 1) & 255;
      18:      return (a + b) & 255;
      19:      return (a - b) & 255;
      default: return (a * b) & 255;
    endcase
  endfunction

  always @(negedge CLK) begin
    logic e_r0, e_r1, e_rv;
    e_r0 = !RST && !m_busy && v0 && (!v1 || !m_ptr);
    e_r1 = !RST && !m_busy && v1 && (!v0 || m_ptr);
    e_rv = m_busy && (cyc >= m_due);
    chk(r0 === e_r0, "req0_ready", int'(r0), int'(e_r0));
    chk(r1 === e_r1, "req1_ready", int'(r1), int'(e_r1));
    if (m_init) begin
      chk(rv === e_rv, "resp_valid", int'(rv), int'(e_rv));
      if (e_rv) begin
        chk(int'(rdata) == m_data, "resp_data", int'(rdata), m_data);
        chk(int'(rid) == int'(m_id), "resp_id", int'(rid), int'(m_id));
      end
    end
    // observation of the DUT for literal checks
    if (rv && resp_ready) act.push_back('{id: int'(rid), data: int'(rdata)});
    if (r0 && v0) acc0++;
    if (r1 && v1) acc1++;
    if ((r0 && v0) || (r1 && v1)) acc_cyc = cyc;
    if (rv && !prev_rv) last_lat = cyc - acc_cyc;
    prev_rv = rv;
    // advance model across the coming edge
    if (RST) begin
      m_init = 1'b1;
      m_busy = 1'b0;
      m_ptr  = 1'b0;
    end else if (m_init) begin
      if (e_rv && resp_ready) begin
        m_busy = 1'b0;
        m_ptr  = ~m_id;
      end else if ((e_r0 && v0) || (e_r1 && v1)) begin
        m_busy = 1'b1;
        m_id   = e_r1;
        if (e_r1) begin
          m_data = model_result(int'(op1), int'(a1), int'(b1));
          m_due  = cyc + ((op1 inside {8'd17, 8'd18, 8'd19}) ? 2 : MUL_LAT);
        end else begin
          m_data = model_result(int'(op0), int'(a0), int'(b0));
          m_due  = cyc + ((op0 inside {8'd17, 8'd18, 8'd19}) ? 2 : MUL_LAT);
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_resp(input int n, input int budget, input string name);
    int k = 0;
    while (act.size() < n && k < budget) begin step(); k++; end
    if (act.size() < n) chk(1'b0, name, act.size(), n);
  endtask

  task automatic wait_acc(input int which, input int target, input int budget, input string name);
    int k = 0;
    while (((which == 0) ? acc0 : acc1) < target && k < budget) begin step(); k++; end
    if (((which == 0) ? acc0 : acc1) < target) chk(1'b0, name, (which == 0) ? acc0 : acc1, target);
  endtask

  task automatic chk_resp(input int idx, input int id, input int data);
    if (idx >= act.size()) begin
      chk(1'b0, $sformatf("resp%0d_present", idx), act.size(), idx + 1);
    end else begin
      chk(act[idx].id == id, $sformatf("resp%0d_id", idx), act[idx].id, id);
      chk(act[idx].data == data, $sformatf("resp%0d_data", idx), act[idx].data, data);
    end
  endtask

  initial begin
    // reset with both requesters already valid and held
    v0 = 1'b1; op0 = 8'd18; a0 = 8'd200; b0 = 8'd100;
    v1 = 1'b1; op1 = 8'd19; a1 = 8'd5;   b1 = 8'd10;
    RST = 1'b1;
    step();
    step();
    chk(rv == 1'b0, "reset_resp_valid", int'(rv), 0);
    chk(rdata == 8'd0, "reset_resp_data", int'(rdata), 0);
    chk(rid == 1'b0, "reset_resp_id", int'(rid), 0);
    RST = 1'b0;

    wait_resp(3, 40, "timeout_contention");
    v0 = 1'b0; v1 = 1'b0;
    chk_resp(0, 0, 44);
    chk_resp(1, 1, 251);
    chk_resp(2, 0, 44);

    // INC wrap, REQ0 alone
    op0 = 8'd17; a0 = 8'hFF; b0 = 8'd0; v0 = 1'b1;
    wait_acc(0, acc0 + 1, 20, "timeout_inc_accept");
    v0 = 1'b0;
    wait_resp(4, 20, "timeout_inc_resp");
    chk_resp(3, 0, 8'h00);
    chk(last_lat == 2, "inc_latency", last_lat, 2);

    // truncated multiply on REQ1
    op1 = 8'h20; a1 = 8'd20; b1 = 8'd20; v1 = 1'b1;
    wait_acc(1, acc1 + 1, 20, "timeout_mul_accept");
    v1 = 1'b0;
    wait_resp(5, 20, "timeout_mul_resp");
    chk_resp(4, 1, 8'h90);
    chk(last_lat == MUL_LAT, "mul_latency", last_lat, MUL_LAT);

    // back-pressure in DONE with the other requester waiting
    resp_ready = 1'b0;
    op0 = 8'd18; a0 = 8'd1; b0 = 8'd2; v0 = 1'b1;
    op1 = 8'd19; a1 = 8'd9; b1 = 8'd4; v1 = 1'b1;
    wait_acc(0, acc0 + 1, 20, "timeout_bp_accept");
    v0 = 1'b0;
    begin
      int k = 0;
      while (!rv && k < 20) begin step(); k++; end
      chk(rv == 1'b1, "bp_resp_valid_rises", int'(rv), 1);
    end
    repeat (10) step();
    chk(rv == 1'b1, "bp_hold_valid", int'(rv), 1);
    chk(rdata == 8'd3, "bp_hold_data", int'(rdata), 3);
    chk(r1 == 1'b0, "bp_hold_req1_ready", int'(r1), 0);
    resp_ready = 1'b1;
    wait_acc(1, acc1 + 1, 20, "timeout_bp_next_accept");
    v1 = 1'b0;
    wait_resp(7, 20, "timeout_bp_resp");
    chk_resp(5, 0, 3);
    chk_resp(6, 1, 5);

    // reset in EXEC discards the operation
    op0 = 8'd19; a0 = 8'd3; b0 = 8'd5; v0 = 1'b1;
    wait_acc(0, acc0 + 1, 20, "timeout_abort_accept");
    RST = 1'b1; v0 = 1'b0;
    step();
    RST = 1'b0;
    repeat (6) step();
    chk(act.size() == 7, "abort_no_response", act.size(), 7);
    v0 = 1'b1;
    wait_acc(0, acc0 + 1, 20, "timeout_retry_accept");
    v0 = 1'b0;
    wait_resp(8, 20, "timeout_retry_resp");
    chk_resp(7, 0, 254);

    repeat (3) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/enum_alu_arbiter.md
# enum_alu_arbiter

Shares one opcode-driven 8-bit ALU between two requesters. The ALU implements increment, add, subtract and truncated multiply, selected by an opcode enum. Each requester has a valid/ready request port. The block arbitrates round-robin, sequences one operation at a time through a small FSM, and returns a registered result tagged with the requester ID on a valid/ready response port. It sits between producer logic and the shared ALU datapath, so the ALU itself never sees contention.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits.

Ports:
- CLK  in  1  the single clock; all state changes on its rising edge.
- RST  in  1  reset, synchronous and active-high.
- REQ0_VALID / REQ1_VALID  in  1  requester i presents an operation.
- REQ0_READY / REQ1_READY  out  1  requester i's operation is accepted this cycle.
- REQ0_OP / REQ1_OP  in  8  opcode: 17 INC, 18 ADD, 19 SUB, any other value MUL.
- REQ0_A / REQ1_A, REQ0_B / REQ1_B  in  WIDTH  operands.
- RESP_VALID  out  1  result available.
- RESP_READY  in  1  consumer accepts the result.
- RESP_DATA  out  WIDTH  result.
- RESP_ID  out  1  index of the requester that issued the operation.

## Operation
- Handshake: a transfer happens when VALID and READY are both high at a rising edge.
  - VALID, OP, A and B must stay stable until READY is seen.
  - RESP_VALID, RESP_DATA and RESP_ID stay stable until RESP_READY is seen.
- FSM states: IDLE, EXEC, MULX (exists only with the macro), DONE.
  - IDLE:
    - REQi_READY is high only for the granted requester: high when the state is IDLE, REQi_VALID is high, and the arbiter picks i.
    - Grant is combinational from the current VALIDs.
    - If only one requester is valid, it wins.
    - If both are valid, the requester at the round-robin pointer PTR wins.
    - On a handshake, capture OP, A, B and ID, then go to EXEC.
  - EXEC:
    - Compute and register RESP_DATA and RESP_ID, then go to DONE.
    - With the macro and a MUL opcode, go to MULX instead of DONE.
  - MULX: register the product into RESP_DATA, then go to DONE.
  - DONE: RESP_VALID is high. On RESP_READY, go to IDLE and set PTR to the complement of the served ID.
- Arithmetic is modulo 2^WIDTH:
  - INC = A+1
  - ADD = A+B
  - SUB = A−B (wraps)
  - MUL = low WIDTH bits of the 2·WIDTH product.
- Reset values:
  - State IDLE, PTR=0.
  - RESP_VALID=0, RESP_DATA=0, RESP_ID=0.
  - Both READYs 0 during the reset cycle.
- Reset mid-operation aborts the operation: the result is discarded and no response is issued.
- A requester whose VALID drops while it is not granted loses nothing. Rule violations by the requester are not checked.

## Timing
- Handshake at edge N → EXEC in cycle N+1 → RESP_VALID high in cycle N+2.
- MUL with the macro: RESP_VALID high in cycle N+3.
- Minimum spacing between accepts is 3 cycles (4 for a pipelined MUL), since DONE→IDLE→accept.
- Back-pressure: RESP_READY low holds DONE indefinitely. No REQ_READY is asserted meanwhile.
- A requester waits at most one other operation (round-robin fairness).

## Configuration
- ENUM_ALU_ARB_MUL_PIPE_EN defined:
  - MUL passes through MULX.
  - Operands are registered in EXEC; the multiply result is registered in MULX.
  - Adds one cycle of latency, for timing closure at wide WIDTH.
- ENUM_ALU_ARB_MUL_PIPE_EN undefined:
  - The MULX state does not exist.
  - All opcodes complete in EXEC.

## Structure
- Shared package enum_alu_pkg holds:
  - The opcode constants OP_INC=17, OP_ADD=18, OP_SUB=19.
  - The FSM state enum typedef.
- One sub-module, enum_alu: a purely combinational opcode → result unit (WIDTH-parameterized), instantiated once.
- Arbitration, FSM and registers stay in enum_alu_arbiter.

## Test plan
- Reset held 2 cycles with both VALIDs high → RESP_VALID=0 and both READYs 0 throughout. After release, REQ0 is granted first (PTR=0).
- REQ0 only, OP=17, A=0xFF → REQ0_READY at edge N, RESP_VALID in cycle N+2, RESP_DATA=0x00, RESP_ID=0.
- REQ0 and REQ1 both valid and held:
  - REQ0: OP=18, A=200, B=100.
  - REQ1: OP=19, A=5, B=10.
  - Expected: responses 44 (ID 0), then 251 (ID 1), then ID 0 again. Grants alternate.
- OP=0x20, A=20, B=20 → RESP_DATA=0x90. Latency is 2 cycles without the macro and 3 with ENUM_ALU_ARB_MUL_PIPE_EN.
- RESP_READY held low 10 cycles in DONE → RESP_DATA stable and both REQ_READYs low. Releasing RESP_READY resumes; the next grant goes to the other requester.
- RST asserted in EXEC → no response is issued. The requester's next request is served normally with a correct result.
